// File: rtl/reg_file_mp_if.sv
// Decode/writeback bus of the multi-port register file.
// The master drives indices, writes and reserves; the slave returns read data, stall flags and the scoreboard.
`timescale 1ns/1ps
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [NUM_RD*ADDR_W-1:0] rd_id;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     we0;
  logic [ADDR_W-1:0]        wid0;
  logic [DATA_W-1:0]        wdata0;
  logic                     we1;
  logic [ADDR_W-1:0]        wid1;
  logic [DATA_W-1:0]        wdata1;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_id;
  logic [DEPTH-1:0]         pending;

  modport master (
    output rd_id, we0, wid0, wdata0, we1, wid1, wdata1, rsv_en, rsv_id,
    input  rd_data, rd_busy, pending
  );

  modport slave (
    input  rd_id, we0, wid0, wdata0, we1, wid1, wdata1, rsv_en, rsv_id,
    output rd_data, rd_busy, pending
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file: N bypassed read ports, two prioritised write ports,
// and a per-register pending scoreboard. Register 0 is hardwired zero.
`timescale 1ns/1ps
module reg_file_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input logic           reg_file_mp_clk,
  input logic           reg_file_mp_rst,
  reg_file_mp_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pending_q;
  logic [DEPTH-1:0]  pending_d;

  // Port 1 is applied last so it wins a same-index collision.
  always_comb begin
    regs_d = regs_q;
    if (bus.we0) regs_d[bus.wid0] = bus.wdata0;
    if (bus.we1) regs_d[bus.wid1] = bus.wdata1;
    regs_d[0] = '0;
  end

  // Set after clear: a reserve racing a writeback belongs to a newer producer.
  always_comb begin
    pending_d = pending_q;
    if (bus.we0)    pending_d[bus.wid0]   = 1'b0;
    if (bus.we1)    pending_d[bus.wid1]   = 1'b0;
    if (bus.rsv_en) pending_d[bus.rsv_id] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge reg_file_mp_clk or posedge reg_file_mp_rst) begin
    if (reg_file_mp_rst) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
      pending_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= regs_d[r];
      pending_q <= pending_d;
    end
  end

  // Write-first bypass; a same-cycle writeback also releases the stall.
  always_comb begin
    logic [ADDR_W-1:0] rid;
    logic              hit0;
    logic              hit1;
    rid          = '0;
    hit0         = 1'b0;
    hit1         = 1'b0;
    bus.rd_data  = '0;
    bus.rd_busy  = '0;
    if (!reg_file_mp_rst) begin
      for (int i = 0; i < NUM_RD; i++) begin
        rid  = bus.rd_id[i*ADDR_W +: ADDR_W];
        hit0 = bus.we0 && (bus.wid0 == rid);
        hit1 = bus.we1 && (bus.wid1 == rid);
        if (rid == '0)
          bus.rd_data[i*DATA_W +: DATA_W] = '0;
        else if (hit1)
          bus.rd_data[i*DATA_W +: DATA_W] = bus.wdata1;
        else if (hit0)
          bus.rd_data[i*DATA_W +: DATA_W] = bus.wdata0;
        else
          bus.rd_data[i*DATA_W +: DATA_W] = regs_q[rid];
        bus.rd_busy[i] = pending_q[rid] & ~(hit0 | hit1);
      end
    end
  end

  assign bus.pending = pending_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: reset, writes, port priority, bypass,
// scoreboard set/clear races and asynchronous reset between edges.
`timescale 1ns/1ps
module tb_reg_file_mp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic clk;
  logic rst;
  int   chk_cnt;
  int   err_cnt;

  reg_file_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  reg_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .reg_file_mp_clk (clk),
    .reg_file_mp_rst (rst),
    .bus             (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we0    = 1'b0;
    bus.wid0   = '0;
    bus.wdata0 = '0;
    bus.we1    = 1'b0;
    bus.wid1   = '0;
    bus.wdata1 = '0;
    bus.rsv_en = 1'b0;
    bus.rsv_id = '0;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] id0, input logic [ADDR_W-1:0] id1);
    bus.rd_id = {id1, id0};
    #1;
  endtask

  initial begin
    chk_cnt = 0;
    err_cnt = 0;
    rst     = 1'b1;
    idle();
    bus.rd_id = '0;
    #12;
    check("rst_pending", bus.pending, 64'h0);
    rst = 1'b0;
    #1;

    // 1. every index reads zero on both ports after reset
    for (int r = 0; r < 32; r++) begin
      set_rd(r[ADDR_W-1:0], 5'(31 - r));
      check("init_rd0",  bus.rd_data[31:0],  64'h0);
      check("init_rd1",  bus.rd_data[63:32], 64'h0);
      check("init_busy", bus.rd_busy,        64'h0);
    end
    check("init_pending", bus.pending, 64'h0);

    // 2. basic write, then register 0 ignores writes and bypass
    bus.we0 = 1'b1; bus.wid0 = 5'd5; bus.wdata0 = 32'd1234;
    step();
    idle();
    set_rd(5'd5, 5'd0);
    check("wr5_rd0", bus.rd_data[31:0], 64'd1234);
    bus.we0 = 1'b1; bus.wid0 = 5'd0; bus.wdata0 = 32'd99;
    set_rd(5'd0, 5'd5);
    check("r0_bypass", bus.rd_data[31:0],  64'd0);
    check("r5_port1",  bus.rd_data[63:32], 64'd1234);
    step();
    idle();
    set_rd(5'd0, 5'd0);
    check("r0_stored", bus.rd_data[31:0], 64'd0);

    // 3. same-index collision: port 1 wins, in bypass and in storage
    bus.we0 = 1'b1; bus.wid0 = 5'd7; bus.wdata0 = 32'd111;
    bus.we1 = 1'b1; bus.wid1 = 5'd7; bus.wdata1 = 32'd222;
    set_rd(5'd7, 5'd7);
    check("coll_byp1", bus.rd_data[63:32], 64'd222);
    check("coll_byp0", bus.rd_data[31:0],  64'd222);
    step();
    idle();
    set_rd(5'd0, 5'd7);
    check("coll_store", bus.rd_data[63:32], 64'd222);

    // port 0 only bypass
    bus.we0 = 1'b1; bus.wid0 = 5'd5; bus.wdata0 = 32'h0DEF;
    set_rd(5'd5, 5'd7);
    check("byp_w0", bus.rd_data[31:0],  64'h0DEF);
    check("byp_ns", bus.rd_data[63:32], 64'd222);
    step();
    idle();

    // 4. reserve, stall, writeback releases stall in the same cycle
    bus.rsv_en = 1'b1; bus.rsv_id = 5'd9;
    set_rd(5'd9, 5'd0);
    check("rsv_same_cyc_busy", bus.rd_busy[0], 64'd0);
    step();
    idle();
    #1;
    check("rsv_busy",    bus.rd_busy[0],  64'd1);
    check("rsv_pend9",   bus.pending[9],  64'd1);
    bus.we1 = 1'b1; bus.wid1 = 5'd9; bus.wdata1 = 32'd4231;
    #1;
    check("wb_busy_rel", bus.rd_busy[0],    64'd0);
    check("wb_byp_data", bus.rd_data[31:0], 64'd4231);
    step();
    idle();
    #1;
    check("wb_pend9",  bus.pending[9],    64'd0);
    check("wb_stored", bus.rd_data[31:0], 64'd4231);

    // 5. reserve and write on the same edge: set wins, data stored
    bus.rsv_en = 1'b1; bus.rsv_id = 5'd3;
    bus.we0 = 1'b1; bus.wid0 = 5'd3; bus.wdata0 = 32'd55;
    step();
    idle();
    set_rd(5'd3, 5'd0);
    check("race_pend3", bus.pending[3],    64'd1);
    check("race_data3", bus.rd_data[31:0], 64'd55);
    check("race_busy",  bus.rd_busy[0],    64'd1);

    // different indices on both ports; reserve of 0 ignored
    bus.we0 = 1'b1; bus.wid0 = 5'd10; bus.wdata0 = 32'hAAAA_0001;
    bus.we1 = 1'b1; bus.wid1 = 5'd11; bus.wdata1 = 32'hBBBB_0002;
    bus.rsv_en = 1'b1; bus.rsv_id = 5'd0;
    step();
    idle();
    set_rd(5'd10, 5'd11);
    check("dual_w0",   bus.rd_data[31:0],  64'hAAAA_0001);
    check("dual_w1",   bus.rd_data[63:32], 64'hBBBB_0002);
    check("rsv0_pend", bus.pending,        64'h0000_0008);

    // 6. fill regs 1..4, reserve 2, then reset between edges
    bus.we0 = 1'b1; bus.wid0 = 5'd1; bus.wdata0 = 32'd11;
    bus.we1 = 1'b1; bus.wid1 = 5'd2; bus.wdata1 = 32'd22;
    step();
    bus.wid0 = 5'd3; bus.wdata0 = 32'd33;
    bus.wid1 = 5'd4; bus.wdata1 = 32'd44;
    step();
    idle();
    bus.rsv_en = 1'b1; bus.rsv_id = 5'd2;
    step();
    idle();
    set_rd(5'd2, 5'd4);
    check("pre_rst_busy", bus.rd_busy,       64'h1);
    check("pre_rst_r4",   bus.rd_data[63:32], 64'd44);
    #1;
    rst = 1'b1;
    bus.we1 = 1'b1; bus.wid1 = 5'd4; bus.wdata1 = 32'hFFFF;
    #1;
    check("rst_rd0",     bus.rd_data[31:0],  64'd0);
    check("rst_rd1_byp", bus.rd_data[63:32], 64'd0);
    check("rst_busy",    bus.rd_busy,        64'd0);
    check("rst_pend",    bus.pending,        64'h0);
    idle();
    #1;
    rst = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      set_rd(r[ADDR_W-1:0], 5'd0);
      check("post_rst_clr", bus.rd_data[31:0], 64'd0);
    end

    // first edge after release performs normal writes and reserves
    bus.we0 = 1'b1; bus.wid0 = 5'd4; bus.wdata0 = 32'd77;
    bus.rsv_en = 1'b1; bus.rsv_id = 5'd6;
    step();
    idle();
    set_rd(5'd4, 5'd6);
    check("post_rst_wr",  bus.rd_data[31:0], 64'd77);
    check("post_rst_rsv", bus.pending,       64'h0000_0040);
    check("post_rst_busy", bus.rd_busy,      64'h2);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100us");
    $fatal(1);
  end
endmodule
